// File: rtl/index_vec_rebuild_pkg.sv
// Shared definitions for the index -> vector rebuild path.
// Holds the default vector width, the derived index/count widths and the
// FSM state encoding used by index_vec_rebuild.
package index_vec_rebuild_pkg;

  localparam int DEF_VEC_WIDTH = 8;

  // Width of an index able to address every bit of a width-n vector.
  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

  // Width of a population count able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/index_vec_rebuild_onehot_dec.sv
// idx_onehot_dec: combinational index decoder.
// Ports:
//   idx      - bit index to decode
//   onehot   - VEC_WIDTH-bit mask with bit idx set (all zero if out of range)
//   in_range - idx addresses a bit of the vector (idx < VEC_WIDTH)
module idx_onehot_dec #(
  parameter int VEC_WIDTH = 8,
  parameter int IDX_WIDTH = $clog2(VEC_WIDTH)
) (
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [VEC_WIDTH-1:0] onehot,
  output logic                 in_range
);

  // Explicit compare per bit keeps non-power-of-two widths exact: indices
  // at or above VEC_WIDTH match no bit and leave in_range low.
  always_comb begin
    onehot   = '0;
    in_range = 1'b0;
    for (int unsigned i = 0; i < VEC_WIDTH; i++) begin
      if (idx == IDX_WIDTH'(i)) begin
        onehot[i] = 1'b1;
        in_range  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/index_vec_rebuild.sv
// index_vec_rebuild: rebuilds a request vector from a stream of bit indices.
// Each accepted beat sets one bit (unless empty); the beat flagged last
// closes the vector, which is presented on a registered output handshake
// together with its population count, an out-of-range flag and a
// duplicate-index flag.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   s_idx/s_empty/s_last/s_valid/s_ready - input beat handshake
//   m_vec/m_count/m_err/m_dup           - rebuilt vector and its status
//   m_valid/m_ready                     - output vector handshake
module index_vec_rebuild
  import index_vec_rebuild_pkg::*;
#(
  parameter  int VEC_WIDTH = DEF_VEC_WIDTH,
  localparam int IDX_WIDTH = idx_width(VEC_WIDTH),
  localparam int CNT_WIDTH = cnt_width(VEC_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_WIDTH-1:0] s_idx,
  input  logic                 s_empty,
  input  logic                 s_last,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [VEC_WIDTH-1:0] m_vec,
  output logic [CNT_WIDTH-1:0] m_count,
  output logic                 m_err,
  output logic                 m_dup,
  output logic                 m_valid,
  input  logic                 m_ready
);

  state_t                 state_q, state_d;
  logic [VEC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   dup_q, dup_d;
  logic [VEC_WIDTH-1:0]   onehot;
  logic                   in_range;
  logic                   hit;
  logic                   fresh;
  logic                   load;
  logic                   unload;

  idx_onehot_dec #(
    .VEC_WIDTH (VEC_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_dec (
    .idx      (s_idx),
    .onehot   (onehot),
    .in_range (in_range)
  );

  assign s_ready = (state_q == COLLECT);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dup_d   = dup_q;
    load    = 1'b0;
    unload  = 1'b0;
    hit     = !s_empty && in_range;
    // Count only bits not already in the accumulator, so a full vector
    // tops out at VEC_WIDTH regardless of repeats.
    fresh   = hit && ((acc_q & onehot) == '0);
    case (state_q)
      COLLECT: begin
        if (s_valid) begin
          if (hit)              acc_d = acc_q | onehot;
          if (fresh)            cnt_d = cnt_q + CNT_WIDTH'(1);
          if (hit && !fresh)    dup_d = 1'b1;
          if (!s_empty && !in_range) err_d = 1'b1;
          if (s_last) begin
            state_d = HOLD;
            load    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = COLLECT;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          dup_d   = 1'b0;
          unload  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dup_q   <= 1'b0;
      m_vec   <= '0;
      m_count <= '0;
      m_err   <= 1'b0;
      m_dup   <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dup_q   <= dup_d;
      // Output registers take the merged values of the last beat directly,
      // so the vector is visible the cycle after the last beat is accepted.
      if (load) begin
        m_vec   <= acc_d;
        m_count <= cnt_d;
        m_err   <= err_d;
        m_dup   <= dup_d;
        m_valid <= 1'b1;
      end else if (unload) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_index_vec_rebuild.sv
// Directed testbench for index_vec_rebuild: one 8-bit instance and one
// 6-bit instance (non-power-of-two width, exercises out-of-range indices).
module tb_index_vec_rebuild;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] s_idx;
  logic       s_empty, s_last, m_ready;
  logic       s_valid8, s_valid6;
  logic       s_ready8, s_ready6;
  logic [7:0] m_vec8;
  logic [5:0] m_vec6;
  logic [3:0] m_count8;
  logic [2:0] m_count6;
  logic       m_err8, m_err6, m_dup8, m_dup6, m_valid8, m_valid6;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  index_vec_rebuild #(.VEC_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s_idx(s_idx), .s_empty(s_empty),
    .s_last(s_last), .s_valid(s_valid8), .s_ready(s_ready8),
    .m_vec(m_vec8), .m_count(m_count8), .m_err(m_err8), .m_dup(m_dup8),
    .m_valid(m_valid8), .m_ready(m_ready)
  );

  index_vec_rebuild #(.VEC_WIDTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .s_idx(s_idx), .s_empty(s_empty),
    .s_last(s_last), .s_valid(s_valid6), .s_ready(s_ready6),
    .m_vec(m_vec6), .m_count(m_count6), .m_err(m_err6), .m_dup(m_dup6),
    .m_valid(m_valid6), .m_ready(m_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a falling edge; presents one beat for one rising edge.
  task automatic send(input bit to6, input logic [2:0] idx, input logic empty, input logic last);
    s_idx   = idx;
    s_empty = empty;
    s_last  = last;
    if (to6) s_valid6 = 1'b1;
    else     s_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid6 = 1'b0;
    s_valid8 = 1'b0;
    s_last   = 1'b0;
    s_empty  = 1'b0;
  endtask

  task automatic handshake(input bit is6);
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    check("hs_valid_drop", is6 ? m_valid6 : m_valid8, 0);
    check("hs_ready_back", is6 ? s_ready6 : s_ready8, 1);
  endtask

  initial begin
    rst_n = 1'b0; s_idx = '0; s_empty = 1'b0; s_last = 1'b0;
    s_valid8 = 1'b0; s_valid6 = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_vec",   m_vec8, 0);
    check("rst_count", m_count8, 0);
    check("rst_flags", {m_err8, m_dup8, m_valid8}, 0);
    check("rst_6",     {m_vec6, m_count6, m_err6, m_dup6, m_valid6}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready8", s_ready8, 1);
    check("rst_ready6", s_ready6, 1);

    // 5, 2, 7(last)
    send(0, 3'd5, 0, 0);
    send(0, 3'd2, 0, 0);
    check("t1_not_yet", m_valid8, 0);
    send(0, 3'd7, 0, 1);
    check("t1_valid", m_valid8, 1);
    check("t1_ready", s_ready8, 0);
    check("t1_vec", m_vec8, 8'hA4);
    check("t1_count", m_count8, 3);
    check("t1_err_dup", {m_err8, m_dup8}, 0);
    handshake(0);

    // single empty last beat
    send(0, 3'd6, 1, 1);
    check("t2_valid", m_valid8, 1);
    check("t2_vec", m_vec8, 0);
    check("t2_count", m_count8, 0);
    check("t2_err_dup", {m_err8, m_dup8}, 0);
    handshake(0);

    // 3, idle gap, 3, 1(last): duplicate index
    send(0, 3'd3, 0, 0);
    s_idx = 3'd6;
    @(negedge clk);
    send(0, 3'd3, 0, 0);
    send(0, 3'd1, 0, 1);
    check("t3_vec", m_vec8, 8'h0A);
    check("t3_count", m_count8, 2);
    check("t3_dup", m_dup8, 1);
    check("t3_err", m_err8, 0);
    handshake(0);

    // all eight bits in scrambled order
    send(0, 3'd3, 0, 0); send(0, 3'd7, 0, 0); send(0, 3'd0, 0, 0);
    send(0, 3'd5, 0, 0); send(0, 3'd1, 0, 0); send(0, 3'd6, 0, 0);
    send(0, 3'd2, 0, 0); send(0, 3'd4, 0, 1);
    check("t4_vec", m_vec8, 8'hFF);
    check("t4_count", m_count8, 8);
    check("t4_dup", m_dup8, 0);
    handshake(0);

    // back-pressure: vector 6, 0(last) held 5 cycles with a beat offered
    send(0, 3'd6, 0, 0);
    send(0, 3'd0, 0, 1);
    s_idx = 3'd2; s_last = 1'b1; s_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_ready", s_ready8, 0);
      check("t5_hold_valid", m_valid8, 1);
      check("t5_hold_vec", m_vec8, 8'h41);
      check("t5_hold_count", m_count8, 2);
    end
    s_valid8 = 1'b0; s_last = 1'b0;
    handshake(0);
    send(0, 3'd4, 0, 1);
    check("t5_next_vec", m_vec8, 8'h10);
    check("t5_next_count", m_count8, 1);
    check("t5_next_flags", {m_err8, m_dup8}, 0);
    handshake(0);

    // reset mid-vector
    send(0, 3'd6, 0, 0);
    send(0, 3'd1, 0, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out", {m_vec8, m_count8, m_err8, m_dup8, m_valid8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 3'd0, 0, 1);
    check("t6_vec", m_vec8, 8'h01);
    check("t6_count", m_count8, 1);
    handshake(0);

    // 6-bit instance: 7 is out of range
    send(1, 3'd7, 0, 0);
    send(1, 3'd0, 0, 1);
    check("t7_valid", m_valid6, 1);
    check("t7_vec", m_vec6, 6'b000001);
    check("t7_count", m_count6, 1);
    check("t7_err", m_err6, 1);
    check("t7_dup", m_dup6, 0);
    handshake(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
